scan_sched_1011: RTL and testbench

Round-robin scheduler that shares one serial "1011" Mealy sequence detector among NCH requester channels. Each channel presents a DW-bit word. The scheduler grants one channel at a time, serializes its word MSB-first into the detector, and counts overlapping "1011" matches. It then returns the count with the channel index over a valid/ready result port. It sits between parallel producers and the bit-serial detector datapath, which it owns and sequences.

---
 rtl/scan_sched_1011_pkg.sv | 9 +
 rtl/seq_det_1011_core.sv | 42 ++++
 rtl/scan_sched_1011.sv | 115 +++++++++++
 tb/tb_scan_sched_1011.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_sched_1011_pkg.sv
// Shared types for the round-robin "1011" scan scheduler.
//   fsm_e   : scheduler states (IDLE / SHIFT / DONE)
//   det_e   : detector states (S0 / S1 / S10 / S101)
//   PATTERN : the serial pattern being matched, MSB first
package scan_sched_1011_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} fsm_e;
  typedef enum logic [1:0] {S0, S1, S10, S101} det_e;
  localparam logic [3:0] PATTERN = 4'b1011;
endpackage

// File: rtl/seq_det_1011_core.sv
// Mealy detector for the serial pattern 1011 with overlap.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear back to S0 (held while the scheduler idles)
//   en       : bit_in is valid this cycle; state holds when low
//   bit_in   : serial input bit
//   hit      : combinational, high on the cycle the final pattern bit arrives
module seq_det_1011_core
  import scan_sched_1011_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic hit
);

  det_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst || clr) state_q <= S0;
    else            state_q <= state_d;
  end

  // Prefix-tracking transitions: each state records the longest pattern
  // prefix that is a suffix of the bits seen so far.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        S0:      state_d = (bit_in == PATTERN[3]) ? S1   : S0;
        S1:      state_d = (bit_in == PATTERN[2]) ? S10  : S1;
        S10:     state_d = (bit_in == PATTERN[1]) ? S101 : S0;
        S101:    state_d = (bit_in == PATTERN[0]) ? S1   : S10;
        default: state_d = S0;
      endcase
    end
  end

  assign hit = en && (state_q == S101) && (bit_in == PATTERN[0]);

endmodule

// File: rtl/scan_sched_1011.sv
// Round-robin scheduler sharing one serial 1011 detector among NCH channels.
//   clk, rst   : clock, synchronous active-high reset
//   req, data  : per-channel level request and DW-bit word (ch i at [i*DW +: DW])
//   gnt        : one-hot grant pulse; the granted word is sampled in that cycle
//   busy       : high while a job is shifting or waiting for result acceptance
//   res_*      : valid/ready result port carrying channel index and match count
module scan_sched_1011
  import scan_sched_1011_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CW  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req,
  input  logic [NCH*DW-1:0]       data,
  output logic [NCH-1:0]          gnt,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(NCH)-1:0]  res_ch,
  output logic [CW-1:0]           res_count
);

  localparam int CHW = $clog2(NCH);
  localparam int BCW = $clog2(DW);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);

  fsm_e           state_q, state_d;
  logic [CHW-1:0] rr_q;
  logic [DW-1:0]  sh_q;
  logic [BCW-1:0] bit_cnt_q;
  logic [CW-1:0]  cnt_q;
  logic [CHW-1:0] ch_q;

  logic           found;
  logic [CHW-1:0] gidx;
  int             idx;
  logic           grant_en;
  logic           det_en;
  logic           det_hit;

  // First requester at or after rr_q, searching upward with wrap.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(rr_q) + i) % NCH;
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = CHW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (found && !rst) begin
          grant_en = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: if (bit_cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE:  if (res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      ch_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        sh_q      <= data[int'(gidx)*DW +: DW];
        ch_q      <= gidx;
        cnt_q     <= '0;
        bit_cnt_q <= '0;
        rr_q      <= (gidx == CHW'(NCH - 1)) ? '0 : gidx + 1'b1;
      end else if (state_q == ST_SHIFT) begin
        sh_q      <= {sh_q[DW-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (det_hit && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign det_en = (state_q == ST_SHIFT);

  seq_det_1011_core u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_IDLE),
    .en     (det_en),
    .bit_in (sh_q[DW-1]),
    .hit    (det_hit)
  );

  assign gnt       = grant_en ? (NCH'(1) << gidx) : '0;
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_ch    = ch_q;
  assign res_count = cnt_q;

endmodule

// File: tb/tb_scan_sched_1011.sv
module tb_scan_sched_1011;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] data;
  logic [NCH-1:0]    gnt;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_ch;
  logic [CW-1:0]     res_count;

  scan_sched_1011 #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_count(res_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: count overlapping 1011 windows, MSB first, saturating.
  function automatic int model_cnt(input logic [DW-1:0] w);
    int c = 0;
    for (int i = DW - 1; i >= 3; i--)
      if (w[i -: 4] == 4'b1011) c++;
    if (c > (1 << CW) - 1) c = (1 << CW) - 1;
    return c;
  endfunction

  typedef struct { int ch; int cnt; } exp_t;
  exp_t sb[$];
  exp_t e_push, e_pop;
  int   mon_g;

  // Scoreboard: expectation pushed at grant, checked at result handshake.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (gnt != '0) begin
        chk("gnt_onehot", $countones(gnt), 1);
        mon_g = 0;
        for (int k = 0; k < NCH; k++) if (gnt[k]) mon_g = k;
        e_push.ch  = mon_g;
        e_push.cnt = model_cnt(data[mon_g*DW +: DW]);
        sb.push_back(e_push);
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e_pop = sb.pop_front();
          chk("sb_ch", res_ch, e_pop.ch);
          chk("sb_count", res_count, e_pop.cnt);
        end
      end
    end
  end

  task automatic set_word(input int ch, input logic [DW-1:0] w);
    data[ch*DW +: DW] = w;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1; req = '0; res_ready = 0;
    @(posedge clk); #1; rst = 0;
  endtask

  // One job: request, check grant, latency, backpressure hold, handshake.
  task automatic do_job(input logic [NCH-1:0] r, input int exp_ch,
                        input int exp_cnt, input int hold);
    int n;
    logic [1:0] ch0;
    logic [CW-1:0] c0;
    @(posedge clk); #1; req = r; res_ready = 0;
    n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 20) begin @(negedge clk); n++; end
    chk("job_gnt", gnt, NCH'(1) << exp_ch);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 40);
    chk("job_latency", n, DW + 1);
    chk("job_busy", busy, 1);
    chk("job_ch", res_ch, exp_ch);
    chk("job_count", res_count, exp_cnt);
    ch0 = res_ch; c0 = res_count;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_ch", res_ch, ch0);
      chk("bp_count", res_count, c0);
      chk("bp_no_gnt", gnt, 0);
    end
    @(posedge clk); #1; req = '0; res_ready = 1;
    @(negedge clk);
    chk("hs_no_gnt", gnt, 0);
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_valid", res_valid, 0);
    @(posedge clk); #1; res_ready = 0;
  endtask

  task automatic expect_grant(input int exp_ch);
    int n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 40);
    chk("rr_gnt", gnt, NCH'(1) << exp_ch);
  endtask

  typedef struct { int ch; logic [DW-1:0] w; int cnt; int hold; } vec_t;
  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 8'b10110110, 2, 0};
    vecs[1] = '{3, 8'b10111011, 2, 5};
    vecs[2] = '{2, 8'b11111111, 0, 0};
    vecs[3] = '{2, 8'b00000000, 0, 1};
    vecs[4] = '{1, 8'b00000101, 0, 0};
    vecs[5] = '{1, 8'b10000000, 0, 0};
    vecs[6] = '{0, 8'b00001011, 1, 0};

    rst = 1; req = '0; data = '0; res_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_ch", res_ch, 0);
    chk("rst_count", res_count, 0);
    @(posedge clk); #1; rst = 0;

    foreach (vecs[i]) begin
      set_word(vecs[i].ch, vecs[i].w);
      do_job(NCH'(1) << vecs[i].ch, vecs[i].ch, vecs[i].cnt, vecs[i].hold);
    end

    // Fairness from reset with req=0101: 0, 2, 0.
    do_reset();
    data = {8'hB0, 8'h0B, 8'hFF, 8'hB6};
    req = 4'b0101; res_ready = 1;
    expect_grant(0);
    expect_grant(2);
    expect_grant(0);
    @(posedge clk); #1; req = '0;
    repeat (DW + 4) @(negedge clk);

    // Fairness: after ch2, widen to all channels: 3 then 0.
    do_reset();
    req = 4'b0101; res_ready = 1;
    expect_grant(0);
    expect_grant(2);
    @(posedge clk); #1; req = 4'b1111;
    expect_grant(3);
    expect_grant(0);
    @(posedge clk); #1; req = '0;
    repeat (DW + 4) @(negedge clk);
    chk("drain_busy", busy, 0);

    // Reset during SHIFT discards the job and resets rr_ptr.
    do_reset();
    set_word(2, 8'b10110110);
    @(posedge clk); #1; req = 4'b0100;
    expect_grant(2);
    @(posedge clk); #1; req = '0;
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_valid", res_valid, 0);
    chk("mid_ch", res_ch, 0);
    chk("mid_count", res_count, 0);
    chk("mid_sb_flushed", sb.size(), 0);
    set_word(0, 8'b10110000);
    do_job(4'b1111, 0, 1, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
